axis_fifo_level: RTL and testbench

Next-generation AXI4-Stream FIFO for the streaming datapath. Block RAM storage with a registered read and a registered output stage, plus optional frame (store-and-forward) mode with drop-on-full and drop-on-bad-frame. Adds runtime watermark flags and occupancy counters for flow control and debug.

---
 rtl/axis_fifo_level_pkg.sv | 50 +++++
 rtl/axis_fifo_level_ram.sv | 29 ++
 rtl/axis_fifo_level.sv | 259 +++++++++++++++++++++++++
 tb/tb_axis_fifo_level.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_level_pkg.sv
// Shared helpers for axis_fifo_level: pointer sizing,
// bad-frame matching and the stored-word field layout.
package axis_fifo_level_pkg;

    localparam int DATA_OFFSET = 0;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int keep_offset(input int dw);
        return dw;
    endfunction

    function automatic int last_offset(input int dw, input int kw);
        return dw + kw;
    endfunction

    function automatic int id_offset(input int dw, input int kw);
        return dw + kw + 1;
    endfunction

    function automatic int dest_offset(
        input int dw, input int kw, input int iw
    );
        return dw + kw + 1 + iw;
    endfunction

    function automatic int user_offset(
        input int dw, input int kw, input int iw, input int dsw
    );
        return dw + kw + 1 + iw + dsw;
    endfunction

    function automatic int word_width(
        input int dw, input int kw, input int iw,
        input int dsw, input int uw
    );
        return dw + kw + 1 + iw + dsw + uw;
    endfunction

    function automatic logic bad_frame_match(
        input logic [63:0] user,
        input logic [63:0] value,
        input logic [63:0] mask
    );
        return (user & mask) == (value & mask);
    endfunction

endpackage

// File: rtl/axis_fifo_level_ram.sv
// Simple dual-port storage for axis_fifo_level:
// one write port, one registered read port.
module axis_fifo_level_ram
    import axis_fifo_level_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_fifo_level.sv
// AXI4-Stream FIFO with frame mode, watermarks and occupancy counters.
// Define AXIS_FIFO_LEVEL_PAUSE_EN to add the pause_req/pause_ack output gate.
module axis_fifo_level
    import axis_fifo_level_pkg::*;
#(
    parameter int DEPTH                = 16,
    parameter int DATA_WIDTH           = 8,
    parameter int KEEP_ENABLE          = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH           = DATA_WIDTH / 8,
    parameter int ID_WIDTH             = 8,
    parameter int DEST_WIDTH           = 8,
    parameter int USER_WIDTH           = 1,
    parameter int FRAME_FIFO           = 0,
    parameter int DROP_WHEN_FULL       = 0,
    parameter int DROP_BAD_FRAME       = 0,
    parameter int USER_BAD_FRAME_VALUE = 1,
    parameter int USER_BAD_FRAME_MASK  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [ID_WIDTH-1:0]      s_axis_tid,
    input  logic [DEST_WIDTH-1:0]    s_axis_tdest,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [ID_WIDTH-1:0]      m_axis_tid,
    output logic [DEST_WIDTH-1:0]    m_axis_tdest,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,
    input  logic [$clog2(DEPTH):0]   cfg_afull_thresh,
    input  logic [$clog2(DEPTH):0]   cfg_aempty_thresh,
    output logic [$clog2(DEPTH):0]   status_depth,
    output logic [$clog2(DEPTH):0]   status_depth_commit,
    output logic                     status_almost_full,
    output logic                     status_almost_empty,
    output logic                     status_overflow,
    output logic                     status_bad_frame,
`ifdef AXIS_FIFO_LEVEL_PAUSE_EN
    input  logic                     pause_req,
    output logic                     pause_ack,
`endif
    output logic                     status_good_frame
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam int KEEP_OFF = keep_offset(DATA_WIDTH);
    localparam int LAST_OFF = last_offset(DATA_WIDTH, KEEP_WIDTH);
    localparam int ID_OFF = id_offset(DATA_WIDTH, KEEP_WIDTH);
    localparam int DEST_OFF =
        dest_offset(DATA_WIDTH, KEEP_WIDTH, ID_WIDTH);
    localparam int USER_OFF =
        user_offset(DATA_WIDTH, KEEP_WIDTH, ID_WIDTH, DEST_WIDTH);
    localparam int WW = word_width(
        DATA_WIDTH, KEEP_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);

    localparam bit FRAME = FRAME_FIFO != 0;
    localparam bit DROP_MODE = FRAME && (DROP_WHEN_FULL != 0);
    localparam bit BAD_MODE = FRAME && (DROP_BAD_FRAME != 0);
    localparam logic [USER_WIDTH-1:0] BAD_VAL =
        USER_WIDTH'(USER_BAD_FRAME_VALUE);
    localparam logic [USER_WIDTH-1:0] BAD_MASK =
        USER_WIDTH'(USER_BAD_FRAME_MASK);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_cur;
    logic [PW-1:0] rd_ptr;
    logic          drop_st;

    logic          full_cur;
    logic          empty;
    logic          frame_full;
    logic          s_beat;
    logic          drop_beat;
    logic          wr_en;
    logic          bad_last;
    logic [KEEP_WIDTH-1:0] s_keep;
    logic [WW-1:0] s_word;

    logic          wr_drop_end;
    logic          wr_drop;
    logic          wr_plain;
    logic          wr_mid;
    logic          wr_bad;
    logic          wr_good;

    logic          mem_valid;
    logic [WW-1:0] mem_word;
    logic          m_valid_q;
    logic [WW-1:0] out_word;
    logic          out_ready;
    logic          out_load;
    logic          mem_ready;
    logic          rd_en;
    logic          stall;

    assign full_cur = (wr_ptr_cur[AW] != rd_ptr[AW]) &&
                      (wr_ptr_cur[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign frame_full = (wr_ptr_cur - wr_ptr) == PW'(DEPTH);

    assign s_axis_tready = DROP_MODE ? 1'b1 : !full_cur;
    assign s_beat = s_axis_tvalid && s_axis_tready;
    assign drop_beat = DROP_MODE &&
                       (drop_st || full_cur || frame_full);
    assign wr_en = s_beat && !drop_beat;
    assign bad_last = BAD_MODE && bad_frame_match(
        64'(s_axis_tuser), 64'(BAD_VAL), 64'(BAD_MASK));

    // Unkept lanes are stored as all-ones so the output needs no mux.
    assign s_keep = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
    assign s_word = {s_axis_tuser, s_axis_tdest, s_axis_tid,
                     s_axis_tlast, s_keep, s_axis_tdata};

    assign wr_drop_end = s_beat && drop_beat && s_axis_tlast;
    assign wr_drop = s_beat && drop_beat && !s_axis_tlast;
    assign wr_plain = wr_en && !FRAME;
    assign wr_mid = wr_en && FRAME && !s_axis_tlast;
    assign wr_bad = wr_en && FRAME && s_axis_tlast && bad_last;
    assign wr_good = wr_en && FRAME && s_axis_tlast && !bad_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr            <= '0;
            wr_ptr_cur        <= '0;
            drop_st           <= 1'b0;
            status_overflow   <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_good_frame <= 1'b0;
        end else begin
            status_overflow   <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_good_frame <= 1'b0;
            unique case (1'b1)
                wr_drop_end: begin
                    wr_ptr_cur      <= wr_ptr;
                    drop_st         <= 1'b0;
                    status_overflow <= 1'b1;
                end
                wr_drop: begin
                    drop_st <= 1'b1;
                end
                wr_plain: begin
                    wr_ptr     <= wr_ptr_cur + 1'b1;
                    wr_ptr_cur <= wr_ptr_cur + 1'b1;
                end
                wr_mid: begin
                    wr_ptr_cur <= wr_ptr_cur + 1'b1;
                end
                wr_bad: begin
                    wr_ptr_cur       <= wr_ptr;
                    status_bad_frame <= 1'b1;
                end
                wr_good: begin
                    wr_ptr            <= wr_ptr_cur + 1'b1;
                    wr_ptr_cur        <= wr_ptr_cur + 1'b1;
                    status_good_frame <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    axis_fifo_level_ram #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_cur[AW-1:0]),
        .wr_data (s_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (mem_word)
    );

    // Read register refills whenever it is empty or being drained.
    assign out_ready = !m_valid_q || m_axis_tready;
    assign out_load = mem_valid && out_ready && !stall;
    assign mem_ready = !mem_valid || out_load;
    assign rd_en = mem_ready && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            mem_valid <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (mem_ready) begin
                mem_valid <= !empty;
            end
            if (out_load) begin
                m_valid_q <= 1'b1;
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (out_load) begin
            out_word <= mem_word;
        end
    end

`ifdef AXIS_FIFO_LEVEL_PAUSE_EN
    logic out_mid;

    // Pausing only takes hold on a frame boundary of issued beats.
    assign stall = pause_req && !out_mid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_mid   <= 1'b0;
            pause_ack <= 1'b0;
        end else begin
            if (out_load) begin
                out_mid <= !mem_word[LAST_OFF];
            end
            pause_ack <= pause_req && !out_mid && !m_valid_q;
        end
    end
`else
    assign stall = 1'b0;
`endif

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata = out_word[DATA_OFFSET +: DATA_WIDTH];
    assign m_axis_tkeep = out_word[KEEP_OFF +: KEEP_WIDTH];
    assign m_axis_tlast = out_word[LAST_OFF];
    assign m_axis_tid = out_word[ID_OFF +: ID_WIDTH];
    assign m_axis_tdest = out_word[DEST_OFF +: DEST_WIDTH];
    assign m_axis_tuser = out_word[USER_OFF +: USER_WIDTH];

    assign status_depth = wr_ptr_cur - rd_ptr;
    assign status_depth_commit = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            status_almost_full  <= cfg_afull_thresh == '0;
            status_almost_empty <= 1'b1;
        end else begin
            status_almost_full  <= status_depth >= cfg_afull_thresh;
            status_almost_empty <=
                status_depth_commit <= cfg_aempty_thresh;
        end
    end

endmodule

// File: tb/tb_axis_fifo_level.sv
// Bench for axis_fifo_level: plain, frame/bad-frame and
// drop-when-full instances driven side by side.
module tb_axis_fifo_level;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] s_tdata [N];
    logic       s_tkeep [N];
    logic       s_tvalid [N];
    logic       s_tready [N];
    logic       s_tlast [N];
    logic [7:0] s_tid [N];
    logic [7:0] s_tdest [N];
    logic       s_tuser [N];
    logic [7:0] m_tdata [N];
    logic       m_tkeep [N];
    logic       m_tvalid [N];
    logic       m_tready [N];
    logic       m_tlast [N];
    logic [7:0] m_tid [N];
    logic [7:0] m_tdest [N];
    logic       m_tuser [N];
    logic [4:0] cfg_af [N];
    logic [4:0] cfg_ae [N];
    logic [4:0] depth [N];
    logic [4:0] depthc [N];
    logic       afull [N];
    logic       aempty [N];
    logic       ovf [N];
    logic       bad [N];
    logic       good [N];
`ifdef AXIS_FIFO_LEVEL_PAUSE_EN
    logic       pause_ack [N];
`endif

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        axis_fifo_level #(
            .DEPTH          (16),
            .DATA_WIDTH     (8),
            .FRAME_FIFO     (g > 0 ? 1 : 0),
            .DROP_WHEN_FULL (g == 2 ? 1 : 0),
            .DROP_BAD_FRAME (g > 0 ? 1 : 0)
        ) u_dut (
            .clk                 (clk),
            .rst                 (rst),
            .s_axis_tdata        (s_tdata[g]),
            .s_axis_tkeep        (s_tkeep[g]),
            .s_axis_tvalid       (s_tvalid[g]),
            .s_axis_tready       (s_tready[g]),
            .s_axis_tlast        (s_tlast[g]),
            .s_axis_tid          (s_tid[g]),
            .s_axis_tdest        (s_tdest[g]),
            .s_axis_tuser        (s_tuser[g]),
            .m_axis_tdata        (m_tdata[g]),
            .m_axis_tkeep        (m_tkeep[g]),
            .m_axis_tvalid       (m_tvalid[g]),
            .m_axis_tready       (m_tready[g]),
            .m_axis_tlast        (m_tlast[g]),
            .m_axis_tid          (m_tid[g]),
            .m_axis_tdest        (m_tdest[g]),
            .m_axis_tuser        (m_tuser[g]),
            .cfg_afull_thresh    (cfg_af[g]),
            .cfg_aempty_thresh   (cfg_ae[g]),
            .status_depth        (depth[g]),
            .status_depth_commit (depthc[g]),
            .status_almost_full  (afull[g]),
            .status_almost_empty (aempty[g]),
            .status_overflow     (ovf[g]),
            .status_bad_frame    (bad[g]),
`ifdef AXIS_FIFO_LEVEL_PAUSE_EN
            .pause_req           (1'b0),
            .pause_ack           (pause_ack[g]),
`endif
            .status_good_frame   (good[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int g = 0; g < N; g++) begin
            checks++;
            if (m_tvalid[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset_tvalid[%0d] got %0d want 0", g, m_tvalid[g]);
            end
            checks++;
            if (depth[g] !== 5'd0) begin
                errors++;
                $display("FAIL reset_depth[%0d] got %0d want 0", g, depth[g]);
            end
            checks++;
            if (aempty[g] !== 1'b1) begin
                errors++;
                $display("FAIL reset_aempty[%0d] got %0d want 1", g, aempty[g]);
            end
            checks++;
            if (afull[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset_afull[%0d] got %0d want 0", g, afull[g]);
            end
            checks++;
            if (s_tready[g] !== 1'b1) begin
                errors++;
                $display("FAIL reset_tready[%0d] got %0d want 1", g, s_tready[g]);
            end
        end
    endtask

    task automatic test_fill_drain();
        int n;
        int got;
        n = 0;
        m_tready[0] = 1'b0;
        for (int c = 0; c < 40 && s_tready[0]; c++) begin
            s_tvalid[0] = 1'b1;
            s_tdata[0] = 8'(n);
            tick();
            n++;
        end
        s_tvalid[0] = 1'b0;
        // 16 RAM words plus the read and output registers
        checks++;
        if (n != 18) begin
            errors++;
            $display("FAIL fill_count got %0d want 18", n);
        end
        checks++;
        if (s_tready[0] !== 1'b0) begin
            errors++;
            $display("FAIL fill_tready got %0d want 0", s_tready[0]);
        end
        checks++;
        if (depth[0] !== 5'd16) begin
            errors++;
            $display("FAIL fill_depth got %0d want 16", depth[0]);
        end
        tick();
        checks++;
        if (afull[0] !== 1'b1) begin
            errors++;
            $display("FAIL fill_afull12 got %0d want 1", afull[0]);
        end
        checks++;
        if (aempty[0] !== 1'b0) begin
            errors++;
            $display("FAIL fill_aempty2 got %0d want 0", aempty[0]);
        end
        cfg_af[0] = 5'd16;
        tick();
        checks++;
        if (afull[0] !== 1'b1) begin
            errors++;
            $display("FAIL afull_eq16 got %0d want 1", afull[0]);
        end
        cfg_af[0] = 5'd17;
        tick();
        checks++;
        if (afull[0] !== 1'b0) begin
            errors++;
            $display("FAIL afull_17 got %0d want 0", afull[0]);
        end
        cfg_ae[0] = 5'd16;
        tick();
        checks++;
        if (aempty[0] !== 1'b1) begin
            errors++;
            $display("FAIL aempty_eq16 got %0d want 1", aempty[0]);
        end
        cfg_ae[0] = 5'd15;
        tick();
        checks++;
        if (aempty[0] !== 1'b0) begin
            errors++;
            $display("FAIL aempty_15 got %0d want 0", aempty[0]);
        end
        cfg_af[0] = 5'd12;
        cfg_ae[0] = 5'd2;
        m_tready[0] = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < n; c++) begin
            if (m_tvalid[0]) begin
                checks++;
                if (m_tdata[0] !== 8'(got)) begin
                    errors++;
                    $display("FAIL drain_data got %0d want %0d", m_tdata[0], got);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 18) begin
            errors++;
            $display("FAIL drain_count got %0d want 18", got);
        end
        tick();
        checks++;
        if (depth[0] !== 5'd0 || aempty[0] !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got depth=%0d aempty=%0d want 0 1", depth[0], aempty[0]);
        end
    endtask

    task automatic test_latency();
        m_tready[0] = 1'b0;
        s_tdata[0] = 8'hA5;
        s_tvalid[0] = 1'b1;
        tick();
        s_tvalid[0] = 1'b0;
        checks++;
        if (m_tvalid[0] !== 1'b0 || depthc[0] !== 5'd1) begin
            errors++;
            $display("FAIL lat_n got tvalid=%0d commit=%0d want 0 1", m_tvalid[0], depthc[0]);
        end
        tick();
        checks++;
        if (m_tvalid[0] !== 1'b0 || depthc[0] !== 5'd0) begin
            errors++;
            $display("FAIL lat_n1 got tvalid=%0d commit=%0d want 0 0", m_tvalid[0], depthc[0]);
        end
        tick();
        checks++;
        if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== 8'hA5) begin
            errors++;
            $display("FAIL lat_n2 got tvalid=%0d data=%0h want 1 a5", m_tvalid[0], m_tdata[0]);
        end
        m_tready[0] = 1'b1;
        tick();
        checks++;
        if (m_tvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL lat_consume got %0d want 0", m_tvalid[0]);
        end
    endtask

    task automatic test_frame();
        m_tready[1] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            s_tdata[1] = 8'(10 + b);
            s_tlast[1] = (b == 2);
            s_tvalid[1] = 1'b1;
            tick();
            if (b < 2) begin
                checks++;
                if (m_tvalid[1] !== 1'b0 || depthc[1] !== 5'd0 || depth[1] !== 5'(b + 1)) begin
                    errors++;
                    $display("FAIL frame_uncommitted beat %0d got tvalid=%0d commit=%0d depth=%0d want 0 0 %0d", b, m_tvalid[1], depthc[1], depth[1], b + 1);
                end
            end
        end
        s_tvalid[1] = 1'b0;
        s_tlast[1] = 1'b0;
        checks++;
        if (good[1] !== 1'b1 || m_tvalid[1] !== 1'b0) begin
            errors++;
            $display("FAIL frame_commit got good=%0d tvalid=%0d want 1 0", good[1], m_tvalid[1]);
        end
        tick();
        checks++;
        if (good[1] !== 1'b0 || m_tvalid[1] !== 1'b0) begin
            errors++;
            $display("FAIL frame_t1 got good=%0d tvalid=%0d want 0 0", good[1], m_tvalid[1]);
        end
        for (int b = 0; b < 3; b++) begin
            tick();
            checks++;
            if (m_tvalid[1] !== 1'b1 || m_tdata[1] !== 8'(10 + b) || m_tlast[1] !== (b == 2)) begin
                errors++;
                $display("FAIL frame_out beat %0d got v=%0d d=%0d l=%0d want 1 %0d %0d", b, m_tvalid[1], m_tdata[1], m_tlast[1], 10 + b, b == 2);
            end
        end
        tick();
        checks++;
        if (m_tvalid[1] !== 1'b0) begin
            errors++;
            $display("FAIL frame_end got %0d want 0", m_tvalid[1]);
        end
    endtask

    task automatic test_bad_frame();
        logic seen;
        m_tready[1] = 1'b1;
        s_tdata[1] = 8'd20;
        s_tuser[1] = 1'b0;
        s_tvalid[1] = 1'b1;
        tick();
        checks++;
        if (depth[1] !== 5'd1) begin
            errors++;
            $display("FAIL bad_depth_mid got %0d want 1", depth[1]);
        end
        s_tdata[1] = 8'd21;
        s_tuser[1] = 1'b1;
        s_tlast[1] = 1'b1;
        tick();
        s_tvalid[1] = 1'b0;
        s_tuser[1] = 1'b0;
        s_tlast[1] = 1'b0;
        checks++;
        if (bad[1] !== 1'b1 || good[1] !== 1'b0 || depth[1] !== 5'd0) begin
            errors++;
            $display("FAIL bad_pulse got bad=%0d good=%0d depth=%0d want 1 0 0", bad[1], good[1], depth[1]);
        end
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            seen |= m_tvalid[1];
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL bad_output got %0d want 0", seen);
        end
    endtask

    task automatic test_drop();
        logic early;
        logic rdy_low;
        int got;
        early = 1'b0;
        rdy_low = 1'b0;
        m_tready[2] = 1'b1;
        for (int b = 0; b < 20; b++) begin
            rdy_low |= !s_tready[2];
            s_tdata[2] = 8'(b);
            s_tlast[2] = (b == 19);
            s_tvalid[2] = 1'b1;
            tick();
            if (b < 19) begin
                early |= ovf[2] | m_tvalid[2];
            end
        end
        s_tvalid[2] = 1'b0;
        s_tlast[2] = 1'b0;
        checks++;
        if (rdy_low !== 1'b0 || early !== 1'b0) begin
            errors++;
            $display("FAIL drop_early got rdy_low=%0d early=%0d want 0 0", rdy_low, early);
        end
        checks++;
        if (ovf[2] !== 1'b1 || good[2] !== 1'b0 || depth[2] !== 5'd0) begin
            errors++;
            $display("FAIL drop_ovf got ovf=%0d good=%0d depth=%0d want 1 0 0", ovf[2], good[2], depth[2]);
        end
        for (int b = 0; b < 4; b++) begin
            s_tdata[2] = 8'(40 + b);
            s_tlast[2] = (b == 3);
            s_tvalid[2] = 1'b1;
            tick();
        end
        s_tvalid[2] = 1'b0;
        s_tlast[2] = 1'b0;
        checks++;
        if (good[2] !== 1'b1 || ovf[2] !== 1'b0) begin
            errors++;
            $display("FAIL drop_next_good got good=%0d ovf=%0d want 1 0", good[2], ovf[2]);
        end
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (m_tvalid[2]) begin
                checks++;
                if (m_tdata[2] !== 8'(40 + got) || m_tlast[2] !== (got == 3)) begin
                    errors++;
                    $display("FAIL drop_next_data got d=%0d l=%0d want %0d %0d", m_tdata[2], m_tlast[2], 40 + got, got == 3);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL drop_next_count got %0d want 4", got);
        end
    endtask

    task automatic test_random();
        logic [17:0] sb [$];
        logic [17:0] exp;
        logic [17:0] act;
        int sent;
        int rcvd;
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 60000 && rcvd < 10000; c++) begin
            s_tvalid[0] = (sent < 10000) && (($urandom & 1) == 1);
            s_tdata[0] = 8'($urandom);
            s_tid[0] = 8'($urandom);
            s_tdest[0] = 8'($urandom);
            s_tlast[0] = 1'($urandom);
            s_tuser[0] = 1'($urandom);
            m_tready[0] = ($urandom & 1) == 1;
            if (m_tvalid[0] && m_tready[0]) begin
                act = {m_tdata[0], m_tid[0], m_tdest[0], m_tlast[0], m_tuser[0]};
                exp = (sb.size() > 0) ? sb.pop_front() : ~act;
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL rand_beat %0d got %0h want %0h", rcvd, act, exp);
                end
                rcvd++;
            end
            if (s_tvalid[0] && s_tready[0]) begin
                sb.push_back({s_tdata[0], s_tid[0], s_tdest[0], s_tlast[0], s_tuser[0]});
                sent++;
            end
            checks++;
            if (depth[0] > 5'd16) begin
                errors++;
                $display("FAIL rand_depth got %0d want <=16", depth[0]);
            end
            tick();
        end
        s_tvalid[0] = 1'b0;
        s_tlast[0] = 1'b0;
        s_tuser[0] = 1'b0;
        checks++;
        if (rcvd != 10000) begin
            errors++;
            $display("FAIL rand_count got %0d want 10000", rcvd);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] first;
        logic found;
        m_tready[0] = 1'b0;
        for (int b = 0; b < 6; b++) begin
            s_tdata[0] = 8'(b + 100);
            s_tvalid[0] = 1'b1;
            tick();
        end
        s_tvalid[0] = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (m_tvalid[0] !== 1'b0 || depth[0] !== 5'd0 || depthc[0] !== 5'd0 || aempty[0] !== 1'b1 || s_tready[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst got v=%0d d=%0d dc=%0d ae=%0d rdy=%0d want 0 0 0 1 1", m_tvalid[0], depth[0], depthc[0], aempty[0], s_tready[0]);
        end
        rst = 1'b0;
        m_tready[0] = 1'b1;
        s_tdata[0] = 8'h3C;
        s_tvalid[0] = 1'b1;
        tick();
        s_tvalid[0] = 1'b0;
        found = 1'b0;
        first = 8'h00;
        for (int c = 0; c < 8; c++) begin
            if (m_tvalid[0] && !found) begin
                found = 1'b1;
                first = m_tdata[0];
            end
            tick();
        end
        checks++;
        if (found !== 1'b1 || first !== 8'h3C) begin
            errors++;
            $display("FAIL midrst_after got found=%0d data=%0h want 1 3c", found, first);
        end
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            s_tdata[g] = '0;
            s_tkeep[g] = 1'b1;
            s_tvalid[g] = 1'b0;
            s_tlast[g] = 1'b0;
            s_tid[g] = '0;
            s_tdest[g] = '0;
            s_tuser[g] = 1'b0;
            m_tready[g] = 1'b0;
            cfg_af[g] = 5'd12;
            cfg_ae[g] = 5'd2;
        end
        test_reset();
        test_fill_drain();
        test_latency();
        test_frame();
        test_bad_frame();
        test_drop();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
